// File: rtl/sr_siso_pkg.sv
// Shared constants and stage type for the serial-in/serial-out shift register family.
package sr_siso_pkg;

  localparam int unsigned SR_SISO_DEPTH_DEFAULT = 32'd8;
  localparam logic        SR_SISO_RST_VAL       = 1'b0;

  typedef logic sr_stage_t;

endpackage : sr_siso_pkg

// File: rtl/sr_dff.sv
// Single shift-register stage: D flip-flop with asynchronous active-low reset.
module sr_dff
  import sr_siso_pkg::*;
(
  input  sr_stage_t d,
  input  logic      clk,
  input  logic      reset,
  output sr_stage_t q
);

  sr_stage_t r_q;

  // Stage storage; reset forces the stage to its clear value regardless of clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= SR_SISO_RST_VAL;
    end else begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule : sr_dff

// File: rtl/sr_siso_eight.sv
// DEPTH-stage serial-in/serial-out shift register built from a chain of sr_dff.
// Optional SR_SISO_TAPS_EN exposes every stage on a parallel taps port appended after q.
module sr_siso_eight
  import sr_siso_pkg::*;
#(
  parameter int unsigned DEPTH = SR_SISO_DEPTH_DEFAULT
) (
  input  logic             inp,
  input  logic             clk,
  input  logic             reset,
  output logic             q
`ifdef SR_SISO_TAPS_EN
  ,
  output logic [DEPTH-1:0] taps
`endif
);

  logic [DEPTH-1:0] w_stage;

  // Stage 0 samples inp; every later stage samples its predecessor.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      sr_dff u_dff (
        .d     (inp),
        .clk   (clk),
        .reset (reset),
        .q     (w_stage[gi])
      );
    end else begin : g_body
      sr_dff u_dff (
        .d     (w_stage[gi-1]),
        .clk   (clk),
        .reset (reset),
        .q     (w_stage[gi])
      );
    end
  end

  assign q = w_stage[DEPTH-1];

`ifdef SR_SISO_TAPS_EN
  assign taps = w_stage;
`endif

endmodule : sr_siso_eight

// File: tb/tb_sr_siso_eight.sv
// Self-checking bench for sr_siso_eight using a queue scoreboard of the stage contents.
module tb_sr_siso_eight;

  localparam int DEPTH = 8;

  logic             clk;
  logic             reset;
  logic             inp;
  logic             q;
`ifdef SR_SISO_TAPS_EN
  logic [DEPTH-1:0] taps;
`endif

  int n_checks;
  int n_fails;
  bit exp_q[$];

  sr_siso_eight #(.DEPTH(DEPTH)) dut (
    .inp   (inp),
    .clk   (clk),
    .reset (reset),
    .q     (q)
`ifdef SR_SISO_TAPS_EN
    ,
    .taps  (taps)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Scoreboard holds {stage[DEPTH-1] .. stage[0]}, front = output stage.
  task automatic clear_model();
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(1'b0);
  endtask

  task automatic check_outputs(input string tag);
`ifdef SR_SISO_TAPS_EN
    logic [DEPTH-1:0] exp_taps;
`endif
    check_eq({tag, "_q"}, {63'd0, q}, {63'd0, exp_q[0]});
`ifdef SR_SISO_TAPS_EN
    for (int i = 0; i < DEPTH; i++) exp_taps[DEPTH-1-i] = exp_q[i];
    check_eq({tag, "_taps"}, {56'd0, taps}, {56'd0, exp_taps});
    check_eq({tag, "_taps_msb"}, {63'd0, taps[DEPTH-1]}, {63'd0, q});
`endif
  endtask

  // Drive one bit on the falling edge, shift the model on the rising edge, check 1ns later.
  task automatic step(input string tag, input logic b);
    @(negedge clk);
    inp = b;
    @(posedge clk);
    if (reset) begin
      void'(exp_q.pop_front());
      exp_q.push_back(b);
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic release_reset();
    @(negedge clk);
    inp   = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    logic [7:0] pattern;
    n_checks = 0;
    n_fails  = 0;
    reset    = 1'b0;
    inp      = 1'b0;
    clear_model();
    #1;
    check_outputs("reset_init");

    // Reset hold: clock and data toggle, nothing may be captured.
    for (int i = 0; i < 10; i++) step("reset_hold", logic'(i % 2 == 0));

    // Single pulse appears exactly DEPTH edges after sampling.
    release_reset();
    step("pulse", 1'b1);
    for (int i = 0; i < DEPTH + 3; i++) begin
      step("pulse_tail", 1'b0);
      if (i == DEPTH - 2) check_eq("pulse_at_depth", {63'd0, q}, 64'd1);
    end

    // Alternating input starting at 0.
    for (int i = 0; i < 2 * DEPTH + 4; i++) step("alt", logic'(i % 2));

    // Flush, then byte pattern MSB first.
    for (int i = 0; i < DEPTH; i++) step("flush", 1'b0);
    pattern = 8'b1011_0010;
    for (int i = 7; i >= 0; i--) step("byte", pattern[i]);
    check_eq("byte_first_bit", {63'd0, q}, 64'd1);
`ifdef SR_SISO_TAPS_EN
    check_eq("byte_taps", {56'd0, taps}, {56'd0, pattern});
`endif
    for (int i = 0; i < DEPTH; i++) step("byte_out", 1'b0);

    // Mid-stream reset with the register full of ones.
    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1);
    check_eq("fill_q", {63'd0, q}, 64'd1);
    #2;
    reset = 1'b0;
    #1;
    clear_model();
    check_outputs("midreset_async");
    release_reset();
    for (int i = 0; i < DEPTH + 2; i++) step("after_midreset", 1'b0);

    // Reset asserted coincident with a rising edge while inp is high.
    for (int i = 0; i < 3; i++) step("pre_edge_reset", 1'b1);
    @(negedge clk);
    inp = 1'b1;
    @(posedge clk);
    reset = 1'b0;
    #1;
    clear_model();
    check_outputs("edge_reset");
    release_reset();
    for (int i = 0; i < DEPTH + 1; i++) step("after_edge_reset", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_sr_siso_eight
